// File: rtl/clk_div_bank.sv
// ============================================================================
// clk_div_bank
//
// Multi-channel programmable clock/enable divider. Every channel owns a
// period (N+1 cycles) and a high-time (H cycles). Configuration lands in a
// per-channel shadow and is copied into the active set only at a period
// boundary or while the channel is idle, so a running output never shows a
// shortened or merged pulse. A global sync pulse restarts every running
// channel's period on the next edge, phase-aligning them.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst_n       asynchronous active-low reset
//   ch_en       per-channel run enable
//   sync        global phase-align pulse (affects running channels only)
//   cfg_we      configuration write strobe
//   cfg_ch      channel index for the write (out-of-range writes ignored)
//   cfg_period  period minus one (N)
//   cfg_high    high-time H in cycles
//   div_out     registered divided clock per channel
//   tick        registered one-cycle pulse at the start of each period
//   running     channel is counting
// ============================================================================
module clk_div_bank #(
    parameter int          NUM_CH     = 4,
    parameter int          WIDTH      = 32,
    parameter int unsigned DEF_PERIOD = 1,
    parameter int unsigned DEF_HIGH   = 1,
    localparam int         CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]  cfg_period,
    input  logic [WIDTH-1:0]  cfg_high,
    output logic [NUM_CH-1:0] div_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);

    localparam logic [WIDTH-1:0] DEF_N = WIDTH'(DEF_PERIOD);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEF_HIGH);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [NUM_CH-1:0][WIDTH-1:0] n_sh_q,  n_sh_d;
    logic [NUM_CH-1:0][WIDTH-1:0] h_sh_q,  h_sh_d;
    logic [NUM_CH-1:0][WIDTH-1:0] n_act_q, n_act_d;
    logic [NUM_CH-1:0][WIDTH-1:0] h_act_q, h_act_d;
    logic [NUM_CH-1:0][WIDTH-1:0] cnt_q,   cnt_d;
    logic [NUM_CH-1:0]            run_q,   run_d;
    logic [NUM_CH-1:0]            div_q,   div_d;
    logic [NUM_CH-1:0]            tick_q,  tick_d;

    // Per-channel next-state. Boundary and idle reloads read the shadow's
    // registered (old) value, so a write in the same cycle as a boundary
    // only takes effect at the following boundary.
    always_comb begin
        logic [WIDTH-1:0] cnt_inc;
        cnt_inc = '0;
        n_sh_d  = n_sh_q;
        h_sh_d  = h_sh_q;
        n_act_d = n_act_q;
        h_act_d = h_act_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        div_d   = div_q;
        tick_d  = tick_q;

        for (int i = 0; i < NUM_CH; i++) begin
            // Indices >= NUM_CH match no channel, so such writes drop out.
            if (cfg_we && (cfg_ch == CW'(i))) begin
                n_sh_d[i] = cfg_period;
                h_sh_d[i] = cfg_high;
            end

            cnt_inc = cnt_q[i] + ONE;

            if (!ch_en[i]) begin
                cnt_d[i]   = '0;
                run_d[i]   = 1'b0;
                div_d[i]   = 1'b0;
                tick_d[i]  = 1'b0;
                n_act_d[i] = n_sh_q[i];
                h_act_d[i] = h_sh_q[i];
            end else if (!run_q[i]) begin
                cnt_d[i]  = '0;
                run_d[i]  = 1'b1;
                div_d[i]  = (h_act_q[i] != '0);
                tick_d[i] = 1'b1;
            end else if ((cnt_q[i] == n_act_q[i]) || sync) begin
                cnt_d[i]   = '0;
                n_act_d[i] = n_sh_q[i];
                h_act_d[i] = h_sh_q[i];
                tick_d[i]  = 1'b1;
                div_d[i]   = (h_sh_q[i] != '0);
            end else begin
                // cnt < N_act here, so the increment cannot wrap.
                cnt_d[i]  = cnt_inc;
                tick_d[i] = 1'b0;
                div_d[i]  = (cnt_inc < h_act_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_sh_q  <= {NUM_CH{DEF_N}};
            h_sh_q  <= {NUM_CH{DEF_H}};
            n_act_q <= {NUM_CH{DEF_N}};
            h_act_q <= {NUM_CH{DEF_H}};
            cnt_q   <= '0;
            run_q   <= '0;
            div_q   <= '0;
            tick_q  <= '0;
        end else begin
            n_sh_q  <= n_sh_d;
            h_sh_q  <= h_sh_d;
            n_act_q <= n_act_d;
            h_act_q <= h_act_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
        end
    end

    assign div_out = div_q;
    assign tick    = tick_q;
    assign running = run_q;

endmodule

// File: tb/tb_clk_div_bank.sv
module tb_clk_div_bank;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 32;
    localparam int CW     = 2;

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] ch_en;
    logic              sync;
    logic              cfg_we;
    logic [CW-1:0]     cfg_ch;
    logic [WIDTH-1:0]  cfg_period;
    logic [WIDTH-1:0]  cfg_high;
    logic [NUM_CH-1:0] div_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] running;

    int n_compared;
    int n_mismatched;

    // Reference model: each channel is described by its configured values
    // and its position within the current period; outputs follow from that.
    int unsigned m_sh_n [NUM_CH];
    int unsigned m_sh_h [NUM_CH];
    int unsigned m_n    [NUM_CH];
    int unsigned m_h    [NUM_CH];
    int unsigned m_pos  [NUM_CH];
    bit          m_run  [NUM_CH];

    clk_div_bank #(
        .NUM_CH     (NUM_CH),
        .WIDTH      (WIDTH),
        .DEF_PERIOD (1),
        .DEF_HIGH   (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ch_en      (ch_en),
        .sync       (sync),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .div_out    (div_out),
        .tick       (tick),
        .running    (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void modelReset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_sh_n[c] = 1; m_sh_h[c] = 1;
            m_n[c]    = 1; m_h[c]    = 1;
            m_pos[c]  = 0; m_run[c]  = 0;
        end
    endfunction

    // One clock edge of behaviour, applied with the inputs currently driven.
    function automatic void modelStep();
        for (int c = 0; c < NUM_CH; c++) begin
            if (!ch_en[c]) begin
                m_run[c] = 0;
                m_pos[c] = 0;
                m_n[c]   = m_sh_n[c];
                m_h[c]   = m_sh_h[c];
            end else if (!m_run[c]) begin
                m_run[c] = 1;
                m_pos[c] = 0;
            end else if (m_pos[c] == m_n[c] || sync) begin
                m_pos[c] = 0;
                m_n[c]   = m_sh_n[c];
                m_h[c]   = m_sh_h[c];
            end else begin
                m_pos[c] = m_pos[c] + 1;
            end
        end
        if (cfg_we && int'(cfg_ch) < NUM_CH) begin
            m_sh_n[cfg_ch] = cfg_period;
            m_sh_h[cfg_ch] = cfg_high;
        end
    endfunction

    function automatic logic [NUM_CH-1:0] expRun();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_run[c];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] expTick();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_run[c] && (m_pos[c] == 0);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] expDiv();
        logic [NUM_CH-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c] = m_run[c] && (m_pos[c] < m_h[c]);
        return v;
    endfunction

    // Advance one edge, then compare everything against the model at the
    // falling edge.
    task automatic stepAndCheck(input string tag);
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput({tag, ".div"},  32'(div_out), 32'(expDiv()));
        checkOutput({tag, ".tick"}, 32'(tick),    32'(expTick()));
        checkOutput({tag, ".run"},  32'(running), 32'(expRun()));
    endtask

    task automatic applyStimulus(input logic [NUM_CH-1:0] en, input logic s, input logic we,
                                 input logic [CW-1:0] ch, input int unsigned n, input int unsigned h);
        ch_en      = en;
        sync       = s;
        cfg_we     = we;
        cfg_ch     = ch;
        cfg_period = n;
        cfg_high   = h;
    endtask

    initial begin
        logic [3:0] pat_div;
        n_compared   = 0;
        n_mismatched = 0;
        applyStimulus('0, 1'b0, 1'b0, '0, 0, 0);
        rst_n = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset.div",  32'(div_out), 32'h0);
        checkOutput("reset.tick", 32'(tick),    32'h0);
        checkOutput("reset.run",  32'(running), 32'h0);
        rst_n = 1'b1;

        // ch0 N=3 H=2: fixed pattern 1,1,0,0 with tick every 4th cycle.
        applyStimulus('0, 1'b0, 1'b1, 2'd0, 3, 2);
        stepAndCheck("cfg0");
        applyStimulus('0, 1'b0, 1'b0, 2'd0, 0, 0);
        stepAndCheck("idle0");
        applyStimulus(3'b001, 1'b0, 1'b0, 2'd0, 0, 0);
        pat_div = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            stepAndCheck("pat");
            checkOutput("pat.div0",  32'(div_out[0]), 32'(pat_div[k % 4]));
            checkOutput("pat.tick0", 32'(tick[0]),    32'((k % 4) == 0));
        end

        // Out-of-range write must change nothing.
        applyStimulus(3'b001, 1'b0, 1'b1, 2'd3, 0, 0);
        stepAndCheck("oor");
        applyStimulus(3'b001, 1'b0, 1'b0, 2'd0, 0, 0);
        repeat (4) stepAndCheck("oor_after");

        // Randomized traffic with occasional async reset mid-period.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [NUM_CH-1:0] en;
            int unsigned h;
            for (int c = 0; c < NUM_CH; c++) en[c] = ($urandom_range(0, 19) != 0);
            h = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 8);
            applyStimulus(en, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
                          CW'($urandom_range(0, 3)), $urandom_range(0, 6), h);
            if (cyc % 500 == 250) begin
                @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                modelReset();
                checkOutput("areset.div",  32'(div_out), 32'h0);
                checkOutput("areset.tick", 32'(tick),    32'h0);
                checkOutput("areset.run",  32'(running), 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                stepAndCheck("rnd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock/enable divider; generalised successor to the single-channel toggle divider.
- Each channel has its own period and high-time (duty), and its own enable.
- Configuration is shadowed so that updates apply glitch-free at period boundaries.
- A global sync input phase-aligns all channels.
- Sits between the system clock and slower datapath/peripheral logic.
- Outputs are intended as clock-enables (`tick`) or registered low-speed clock signals (`div_out`).

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- WIDTH, 32, width of period/high-time counters.
- DEF_PERIOD, 1, reset value of every channel's period-minus-one (1 = divide by 2).
- DEF_HIGH, 1, reset value of every channel's high-time in cycles.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ch_en  input  NUM_CH  per-channel run enable.
- sync  input  1  global phase-align pulse.
- cfg_we  input  1  config write strobe.
- cfg_ch  input  max(1,clog2(NUM_CH))  channel index for the write.
- cfg_period  input  WIDTH  period minus one (N); period = N+1 cycles.
- cfg_high  input  WIDTH  high-time H in cycles.
- div_out  output  NUM_CH  registered divided clock per channel.
- tick  output  NUM_CH  registered one-cycle pulse at the start of each period.
- running  output  NUM_CH  channel is counting.

Behaviour:
- Per-channel registers: shadow N_sh/H_sh, active N_act/H_act, cnt[WIDTH], running, div_out, tick.
- Reset (async, rst_n=0): cnt=0, running=0, div_out=0, tick=0; N_sh=N_act=DEF_PERIOD, H_sh=H_act=DEF_HIGH. Asserting mid-operation clears immediately; no partial period is finished.
- Config write: when cfg_we=1, cfg_period/cfg_high are written into channel cfg_ch's shadow on that edge.
  - cfg_ch >= NUM_CH: the write is ignored.
  - Shadows never affect outputs directly.
- Idle (ch_en=0): cnt<=0, running<=0, div_out<=0, tick<=0, N_act<=N_sh, H_act<=H_sh every cycle.
- Start (ch_en=1, running=0): running<=1, cnt<=0, div_out<=(H_act!=0), tick<=1. First period starts on this edge using the active values.
- Run (ch_en=1, running=1):
  - Boundary = (cnt==N_act) or sync=1. At a boundary: cnt<=0, N_act<=N_sh, H_act<=H_sh, tick<=1, div_out<=(H_sh!=0).
  - Otherwise: cnt<=cnt+1, tick<=0, div_out<=((cnt+1)<H_act).
  - Invariant while running: div_out==(cnt<H_act), tick==(cnt==0).
- Disable mid-period (ch_en 1->0): next edge forces idle; div_out goes low with no completion of the period.
- Duty rules:
  - H=0: div_out constantly 0.
  - H>N: div_out constantly 1.
  - N=0: period is 1 cycle; tick stays 1 every cycle; div_out=(H!=0).
- Comparisons are unsigned, WIDTH bits. cnt never exceeds N_act, so there is no wrap-around.
- Simultaneous events:
  - cfg write and boundary on the same channel in the same cycle: active loads the OLD shadow; the new value applies at the next boundary.
  - sync with ch_en rising: the start rule applies (the result is identical).
  - sync affects only running channels. It does not alter shadows.
- Latency: ch_en rise to first tick = 1 edge. Config write to effect = the end of the current period (at most N_act+1 cycles), or the next idle cycle.

Test Plan:
- Reset, then ch0 N=3 H=2, ch_en[0]=1 -> div_out[0] reads 1,1,0,0 repeating; tick[0] is high on every 4th cycle, first tick on the edge after enable; other channels stay 0.
- ch0 running N=3 H=2; at cnt=1 write N=5 H=3 -> cycles cnt=2,3 keep the old pattern (0,0); then 1,1,1,0,0,0 with a period of 6; no short or merged pulses.
- ch0 N=3, ch1 N=5, both running out of phase; pulse sync=1 for one cycle -> next edge both cnt=0 and tick[0]=tick[1]=1 in the same cycle; then each resumes its own period.
- Edge values on ch2: H=0 gives div_out constant 0; N=4 H=7 gives constant 1; N=0 H=1 gives tick and div_out constant 1. Write with cfg_ch=NUM_CH changes nothing.
- Drop ch_en[0] at cnt=2 -> next edge div_out=0, running=0, tick=0. Re-enable -> tick=1 on the first edge and the pattern restarts from cnt=0 with the latest shadow values.
- Assert rst_n=0 asynchronously mid-period (between edges) -> all outputs 0 immediately. Release -> DEF_PERIOD/DEF_HIGH pattern (1,0 divide-by-2) once enabled.
